pipeline_hazard_ctrl: RTL and testbench

Central sequencing unit for the five-stage pipeline. It generates per-latch enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the PC write enable. It gates data-memory requests until `dhit`. It detects load-use and taken-branch hazards, latches `halt`, and keeps a saturating stall-cycle counter. It sits beside the datapath: it consumes stage-status signals and drives only control strobes.

---
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - five-stage pipeline latch enable/flush, data-wait and halt sequencer
//
// Ports:
//   CLK, nRST                  clock (rising edge), asynchronous active-low reset
//   ihit, dhit                 instruction fetch / data access complete this cycle
//   mem_ren, mem_wen, mem_halt MEM-stage load / store / HALT
//   branch_taken               MEM-stage branch or jump resolved taken
//   ex_memread, ex_dest        EX-stage load flag and destination register
//   id_rs, id_rt               ID-stage source registers
//   pc_en                      PC write enable
//   *_en, *_flush              per-latch enable and bubble-insert strobes
//   dmemREN, dmemWEN           data-memory requests, suppressed once halted
//   halt                       sticky halt flag
//   stall_cnt                  saturating count of stall/bubble cycles since reset
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic             mem_halt,
    input  logic             branch_taken,
    input  logic             ex_memread,
    input  logic [4:0]       ex_dest,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic memop;
    logic dstall;
    logic lu;
    logic stall_event;

    assign memop  = mem_ren | mem_wen;
    assign dstall = memop & ~dhit;
    assign lu     = ex_memread & (ex_dest != 5'd0) &
                    ((ex_dest == id_rs) | (ex_dest == id_rt));

    always_comb begin
        state_next  = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        stall_event = 1'b0;

        if (state == HALT) begin
            state_next = HALT;
        end else begin
            dmemREN = mem_ren;
            dmemWEN = mem_wen;

            // A flushed latch must also be enabled so the bubble is captured.
            if (dstall) begin
                // Freeze everything; push a bubble into WB so the MEM
                // instruction is not written back again next cycle.
                memwb_en    = 1'b1;
                memwb_flush = 1'b1;
                stall_event = 1'b1;
            end else if (branch_taken) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (lu) begin
                // Hold PC and IF/ID, bubble into EX for one cycle.
                idex_en     = 1'b1;
                idex_flush  = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                stall_event = 1'b1;
            end else if (!ihit) begin
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                stall_event = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end

            // HALT is not a memory op, so it is only taken on an advancing cycle.
            if (dstall) begin
                state_next = DWAIT;
            end else if (mem_halt) begin
                state_next = HALT;
            end else begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next == HALT) begin
                halt <= 1'b1;
            end
            if (stall_event && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int unsigned CMAX = 65535;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, dhit = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic mem_halt = 1'b0, branch_taken = 1'b0, ex_memread = 1'b0;
    logic [4:0] ex_dest = '0, id_rs = '0, id_rt = '0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic dmemREN, dmemWEN, halt;
    logic [CNT_W-1:0] stall_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_halt(mem_halt),
        .branch_taken(branch_taken), .ex_memread(ex_memread),
        .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Staged stimulus, applied just after the next rising edge.
    logic n_ihit, n_dhit, n_ren, n_wen, n_halt, n_br, n_exmr;
    logic [4:0] n_exd, n_rs, n_rt;

    // Reference model state.
    bit          m_halted;
    int unsigned m_cnt;

    // Scoreboard entries: {pc, ifid_en, idex_en, exmem_en, memwb_en,
    // ifid_fl, idex_fl, exmem_fl, memwb_fl, ren, wen, halt, stall_cnt}
    logic [12+CNT_W-1:0] sb[$];

    int checks = 0;
    int passed = 0;

    // Strobe table per hazard class: 0 data stall, 1 branch, 2 load-use,
    // 3 fetch miss, 4 normal.  en = {pc, ifid, idex, exmem, memwb},
    // fl = {ifid, idex, exmem, memwb}.
    logic [4:0] en_tab[5];
    logic [3:0] fl_tab[5];
    initial begin
        en_tab[0] = 5'b00000; fl_tab[0] = 4'b0001;
        en_tab[1] = 5'b10001; fl_tab[1] = 4'b1110;
        en_tab[2] = 5'b00011; fl_tab[2] = 4'b0100;
        en_tab[3] = 5'b00111; fl_tab[3] = 4'b1000;
        en_tab[4] = 5'b11111; fl_tab[4] = 4'b0000;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    task automatic stage(input logic ih, dh, rr, ww, hh, br, em,
                         input logic [4:0] ed, rs, rt);
        n_ihit = ih; n_dhit = dh; n_ren = rr; n_wen = ww; n_halt = hh;
        n_br = br; n_exmr = em; n_exd = ed; n_rs = rs; n_rt = rt;
    endtask

    task automatic step(input bit rst_n);
        int cls;
        bit is_lu, dst;
        logic [4:0] en;
        logic [3:0] fl;
        logic [11:0] f;
        @(posedge CLK);
        #1;
        nRST = rst_n;
        ihit = n_ihit; dhit = n_dhit; mem_ren = n_ren; mem_wen = n_wen;
        mem_halt = n_halt; branch_taken = n_br; ex_memread = n_exmr;
        ex_dest = n_exd; id_rs = n_rs; id_rt = n_rt;
        if (!rst_n) begin
            m_halted = 0;
            m_cnt = 0;
        end
        dst   = (n_ren || n_wen) && !n_dhit;
        is_lu = n_exmr && n_exd != 0 && (n_exd == n_rs || n_exd == n_rt);
        if (dst) cls = 0;
        else if (n_br) cls = 1;
        else if (is_lu) cls = 2;
        else if (!n_ihit) cls = 3;
        else cls = 4;
        if (m_halted) begin
            f = 12'b0000_0000_0001;
        end else begin
            en = en_tab[cls];
            fl = fl_tab[cls];
            en[3:0] = en[3:0] | fl;
            f = {en, fl, n_ren, n_wen, 1'b0};
        end
        sb.push_back({f, CNT_W'(m_cnt)});
        if (rst_n && !m_halted) begin
            if (cls == 0 || cls == 2 || cls == 3)
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (!dst && n_halt) m_halted = 1;
        end
    endtask

    // Monitor: compares whatever is outstanding at each falling edge.
    always @(negedge CLK) begin
        logic [12+CNT_W-1:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("strobes",
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
                 idex_flush, exmem_flush, memwb_flush, dmemREN, dmemWEN, halt},
                e[12+CNT_W-1:CNT_W]);
            chk("stall_cnt", stall_cnt, e[CNT_W-1:0]);
        end
    end

    initial begin
        int unsigned c0;
        int wait_cnt;
        stage(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0);
        step(0);
        // Normal flow.
        repeat (3) step(1);
        // Load waits three cycles, then completes.
        c0 = m_cnt;
        stage(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1);
        stage(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        stage(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        chk("dwait_stall_cnt", stall_cnt, c0 + 3);
        // Zero-wait store.
        stage(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1);
        // Load-use bubble, then the load moves on.
        stage(1, 0, 0, 0, 0, 0, 1, 5, 1, 5);
        step(1);
        stage(1, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        step(1);
        // Register zero never forms a hazard.
        stage(1, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        step(1);
        // Branch wins over load-use and fetch miss.
        stage(0, 0, 0, 0, 0, 1, 1, 7, 7, 0);
        step(1);
        // Branch held off by a data stall, taken in the dhit cycle.
        stage(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) step(1);
        stage(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        step(1);
        // Asynchronous reset in the middle of a data wait.
        stage(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1);
        step(0);
        stage(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        // Saturation of the stall counter.
        stage(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (65540) step(1);
        stage(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        chk("stall_cnt_saturated", stall_cnt, 16'hFFFF);
        // HALT capture, absorbing state, then reset recovery.
        stage(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1);
        stage(0, 0, 1, 1, 0, 1, 1, 3, 3, 3);
        repeat (4) step(1);
        chk("halt_sticky", halt, 1);
        step(0);
        stage(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1);
        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            stage(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0);
        end
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge CLK);
            wait_cnt++;
        end
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
